// File: rtl/jk_ff_bank.sv
// -----------------------------------------------------------------------------
// jk_ff_bank
//   Bank of WIDTH independent edge-triggered JK flip-flops with complementary
//   outputs. One clock and one asynchronous active-high reset serve every bit.
//   Each bit is its own jk_ff_cell instance, so bits share no logic.
//
//   Per-bit next state on the rising clk edge (reset low):
//     j k : 0 0 hold | 0 1 clear | 1 0 set | 1 1 toggle
//
// Optional build macro:
//   JK_TOGGLE_CNT_EN - adds toggle_cnt, a saturating count of the clock edges
//                      on which at least one bit toggled (j & k != 0).
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-high reset, q <= RESET_VALUE
//   j          in   WIDTH  per-bit set input
//   k          in   WIDTH  per-bit clear input
//   q          out  WIDTH  registered state
//   qn         out  WIDTH  bitwise complement of q
//   toggle_cnt out  CNT_W  toggle-event count (JK_TOGGLE_CNT_EN only)
// -----------------------------------------------------------------------------

// Single JK storage bit. The characteristic equation q+ = j&~q | ~k&q is used
// rather than a case on {j,k} so an X on j or k propagates to q as X instead
// of silently falling into a default branch.
module jk_ff_cell #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= RST_VAL;
      else       q <= (j & ~q) | (~k & q);
   end

endmodule

module jk_ff_bank #(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
   parameter int               CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] q,
`ifdef JK_TOGGLE_CNT_EN
   output logic [CNT_W-1:0] toggle_cnt,
`endif
   output logic [WIDTH-1:0] qn
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         jk_ff_cell #(
            .RST_VAL (RESET_VALUE[gi])
         ) u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j[gi]),
            .k     (k[gi]),
            .q     (q[gi])
         );
      end
   endgenerate

   // Complement taken from the registered state, never from j/k, so qn has
   // the same one-edge latency as q and can never equal it.
   assign qn = ~q;

`ifdef JK_TOGGLE_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic any_tgl;
   assign any_tgl = |(j & k);

   // Saturating: once all-ones the count sticks until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         toggle_cnt <= '0;
      else if (any_tgl && (toggle_cnt != CNT_MAX))
         toggle_cnt <= toggle_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_jk_ff_bank.sv
`timescale 1ns/1ps
module tb_jk_ff_bank;

   logic       clk;
   logic       reset;
   logic       j1, k1;
   logic       q1, qn1;
   logic [3:0] j4, k4, q4, qn4;
`ifdef JK_TOGGLE_CNT_EN
   logic [1:0] cnt1, cnt4;
`endif

   int total  = 0;
   int passed = 0;

   // Scalar default instance: WIDTH=1, RESET_VALUE=0.
   jk_ff_bank #(.CNT_W(2)) u_dut1 (
      .clk        (clk),
      .reset      (reset),
      .j          (j1),
      .k          (k1),
      .q          (q1),
`ifdef JK_TOGGLE_CNT_EN
      .toggle_cnt (cnt1),
`endif
      .qn         (qn1)
   );

   // Four-bit instance with a mixed reset value.
   jk_ff_bank #(.WIDTH(4), .RESET_VALUE(4'b1010), .CNT_W(2)) u_dut4 (
      .clk        (clk),
      .reset      (reset),
      .j          (j4),
      .k          (k4),
      .q          (q4),
`ifdef JK_TOGGLE_CNT_EN
      .toggle_cnt (cnt4),
`endif
      .qn         (qn4)
   );

   // Period 4, rising edges at t = 2, 6, 10, ...
   initial clk = 1'b0;
   always #2 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, got %0t required < 50000", $time);
      $fatal(1, "watchdog");
   end

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; j1 = 1'b0; k1 = 1'b0; j4 = 4'b0; k4 = 4'b0;
      #1; // t=1, before any edge
      total++; if (q1 !== 1'b0 || qn1 !== 1'b1) $display("FAIL reset_pre_edge: q=%b qn=%b required q=0 qn=1", q1, qn1); else passed++;
      total++; if (q4 !== 4'b1010 || qn4 !== 4'b0101) $display("FAIL reset_pre_edge_w4: q=%b qn=%b required 1010/0101", q4, qn4); else passed++;
      #2; // t=3, after the edge at t=2
      total++; if (q1 !== 1'b0 || qn1 !== 1'b1) $display("FAIL reset_held: q=%b qn=%b required q=0 qn=1", q1, qn1); else passed++;
      #2; // t=5
      reset = 1'b0;
   endtask

   task automatic test_set_clear();
      j1 = 1'b1; k1 = 1'b0;
      edge1();
      total++; if (q1 !== 1'b1 || qn1 !== 1'b0) $display("FAIL set: q=%b qn=%b required q=1 qn=0", q1, qn1); else passed++;
      j1 = 1'b0; k1 = 1'b1;
      edge1();
      total++; if (q1 !== 1'b0 || qn1 !== 1'b1) $display("FAIL clear: q=%b qn=%b required q=0 qn=1", q1, qn1); else passed++;
   endtask

   task automatic test_toggle_hold();
      logic exp_q;
      exp_q = 1'b0;
      j1 = 1'b1; k1 = 1'b1;
      for (int n = 0; n < 3; n++) begin
         edge1();
         exp_q = ~exp_q; // 1, 0, 1
         total++; if (q1 !== exp_q || qn1 !== ~exp_q) $display("FAIL toggle_%0d: q=%b qn=%b required q=%b", n, q1, qn1, exp_q); else passed++;
      end
      // Input change between edges must not disturb q.
      j1 = 1'b0; k1 = 1'b1;
      #1;
      j1 = 1'b0; k1 = 1'b0;
      for (int n = 0; n < 3; n++) begin
         edge1();
         total++; if (q1 !== 1'b1) $display("FAIL hold_%0d: q=%b required 1", n, q1); else passed++;
      end
   endtask

   task automatic test_async_reset();
      j1 = 1'b1; k1 = 1'b1;
      j4 = 4'b1111; k4 = 4'b1111;
      edge1(); // q1: 1 -> 0, q4: 1010 -> 0101
      total++; if (q4 !== 4'b0101) $display("FAIL w4_toggle_all: q=%b required 0101", q4); else passed++;
      edge1(); // q1 -> 1, q4 -> 1010
      edge1(); // q1 -> 0, q4 -> 0101
      j1 = 1'b1; // keep toggling
      reset = 1'b1;
      #0.5;
      total++; if (q1 !== 1'b0 || qn1 !== 1'b1) $display("FAIL async_reset_q1: q=%b qn=%b required 0/1", q1, qn1); else passed++;
      total++; if (q4 !== 4'b1010 || qn4 !== 4'b0101) $display("FAIL async_reset_q4: q=%b qn=%b required 1010/0101", q4, qn4); else passed++;
      edge1(); // edge while reset held
      total++; if (q4 !== 4'b1010) $display("FAIL reset_held_edge_w4: q=%b required 1010", q4); else passed++;
      reset = 1'b0;
      j4 = 4'b0; k4 = 4'b0;
      edge1();
      total++; if (q1 !== 1'b1) $display("FAIL resume_toggle_1: q=%b required 1", q1); else passed++;
      edge1();
      total++; if (q1 !== 1'b0) $display("FAIL resume_toggle_2: q=%b required 0", q1); else passed++;
      total++; if (q4 !== 4'b1010) $display("FAIL w4_hold_after_reset: q=%b required 1010", q4); else passed++;
   endtask

   task automatic test_width4_decode();
      j1 = 1'b0; k1 = 1'b0;
      j4 = 4'b0011; k4 = 4'b0101; // [3] hold, [2] clear, [1] set, [0] toggle
      edge1();
      total++; if (q4 !== 4'b1011 || qn4 !== 4'b0100) $display("FAIL w4_decode_1: q=%b qn=%b required 1011/0100", q4, qn4); else passed++;
      edge1();
      total++; if (q4 !== 4'b1010 || qn4 !== 4'b0101) $display("FAIL w4_decode_2: q=%b qn=%b required 1010/0101", q4, qn4); else passed++;
      j4 = 4'b1100; k4 = 4'b0110; // [3] set, [2] toggle, [1] clear, [0] hold
      edge1();
      total++; if (q4 !== 4'b1100) $display("FAIL w4_decode_3: q=%b required 1100", q4); else passed++;
      j4 = 4'b0; k4 = 4'b0;
   endtask

`ifdef JK_TOGGLE_CNT_EN
   task automatic test_toggle_cnt();
      logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      j1 = 1'b0; k1 = 1'b0;
      reset = 1'b1;
      #0.5;
      total++; if (cnt1 !== 2'd0) $display("FAIL cnt_reset: cnt=%0d required 0", cnt1); else passed++;
      edge1();
      reset = 1'b0;
      j1 = 1'b1; k1 = 1'b1;
      for (int n = 0; n < 5; n++) begin
         edge1();
         total++; if (cnt1 !== exp_c[n]) $display("FAIL cnt_edge_%0d: cnt=%0d required %0d", n, cnt1, exp_c[n]); else passed++;
      end
      // Only some bits toggling still counts; no bit toggling does not.
      total++; if (cnt4 !== 2'd0) $display("FAIL cnt_w4_idle: cnt=%0d required 0", cnt4); else passed++;
      j4 = 4'b0100; k4 = 4'b0110;
      edge1();
      total++; if (cnt4 !== 2'd1) $display("FAIL cnt_w4_partial: cnt=%0d required 1", cnt4); else passed++;
      j4 = 4'b0; k4 = 4'b0;
      reset = 1'b1;
      #0.5;
      total++; if (cnt1 !== 2'd0) $display("FAIL cnt_async_clear: cnt=%0d required 0", cnt1); else passed++;
      reset = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_set_clear();
      test_toggle_hold();
      test_async_reset();
      test_width4_decode();
`ifdef JK_TOGGLE_CNT_EN
      test_toggle_cnt();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
